// File: rtl/ir_pulse_timer.sv
// IR receiver front end: synchronises and deglitches IRDA_RXD, times each mark/space
// in microseconds and classifies every completed segment into an NEC symbol code.
module ir_pulse_timer #(
  parameter int CLK_PER_US    = 50,
  parameter int FILTER_CYCLES = 100,
  parameter int LEN_W         = 16,
  parameter int TIMEOUT_US    = 20000
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic             IRDA_RXD,
  output logic             seg_valid,
  output logic             seg_level,
  output logic [LEN_W-1:0] seg_len,
  output logic             seg_sat,
  output logic             sym_valid,
  output logic [2:0]       sym_code,
  output logic             idle
);

  typedef enum logic [2:0] {
    SYM_ERR          = 3'd0,
    SYM_LEAD_MARK    = 3'd1,
    SYM_LEAD_SPACE   = 3'd2,
    SYM_REPEAT_SPACE = 3'd3,
    SYM_BIT_MARK     = 3'd4,
    SYM_BIT0_SPACE   = 3'd5,
    SYM_BIT1_SPACE   = 3'd6,
    SYM_IDLE         = 3'd7
  } sym_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2
  } state_e;

  localparam int PRE_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int FLT_W = $clog2(FILTER_CYCLES + 1);
  localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(CLK_PER_US - 1);
  localparam logic [FLT_W-1:0] FLT_LAST    = FLT_W'(FILTER_CYCLES - 1);
  localparam logic [LEN_W-1:0] LEN_MAX     = {LEN_W{1'b1}};
  localparam logic [LEN_W-1:0] TIMEOUT_LEN = LEN_W'(TIMEOUT_US);

  logic             sync1_q, sync2_q, filt_q, filt_dly_q;
  logic [FLT_W-1:0] flt_cnt_q;
  logic [PRE_W-1:0] pre_q;
  logic [LEN_W-1:0] len_q, len_nx;
  logic             sat_q, sat_nx;
  logic             fall, rise, tick;
  state_e           state_q;

  logic             seg_valid_q, seg_level_q, seg_sat_q, sym_valid_q, idle_q;
  logic [LEN_W-1:0] seg_len_q;
  sym_e             sym_code_q;

  function automatic sym_e classify(input logic lvl, input logic [LEN_W-1:0] len,
                                    input logic sat);
    int unsigned l;
    l = 32'(len);
    classify = SYM_ERR;
    if (!sat) begin
      if (!lvl) begin
        if (l >= 8000 && l <= 10000)    classify = SYM_LEAD_MARK;
        else if (l >= 400 && l <= 700)  classify = SYM_BIT_MARK;
      end else begin
        if (l >= 4000 && l <= 5000)     classify = SYM_LEAD_SPACE;
        else if (l >= 2000 && l <= 2500) classify = SYM_REPEAT_SPACE;
        else if (l >= 400 && l <= 700)  classify = SYM_BIT0_SPACE;
        else if (l >= 1400 && l <= 1900) classify = SYM_BIT1_SPACE;
      end
    end
  endfunction

  // NOTE: the synchroniser and filter reset to 1 so an idle-high line produces no edge at release.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      filt_q     <= 1'b1;
      filt_dly_q <= 1'b1;
      flt_cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep the two synchroniser stages as separate flops.
      sync1_q    <= IRDA_RXD;
      sync2_q    <= sync1_q;
      filt_dly_q <= filt_q;
      if (sync2_q == filt_q) begin
        flt_cnt_q <= '0;
      end else if (flt_cnt_q == FLT_LAST) begin
        filt_q    <= ~filt_q;
        flt_cnt_q <= '0;
      end else begin
        flt_cnt_q <= flt_cnt_q + 1'b1;
      end
    end
  end

  // len_nx already includes the tick of the current cycle, so a captured length is exact
  // for a pulse of whole microseconds.
  always_comb begin
    fall   = filt_dly_q & ~filt_q;
    rise   = ~filt_dly_q & filt_q;
    tick   = (pre_q == PRE_LAST);
    len_nx = len_q;
    sat_nx = sat_q;
    if (tick) begin
      if (len_q == LEN_MAX) sat_nx = 1'b1;
      else                  len_nx = len_q + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      pre_q <= '0;
      len_q <= '0;
      sat_q <= 1'b0;
    end else if (fall || rise) begin
      pre_q <= '0;
      len_q <= '0;
      sat_q <= 1'b0;
    end else begin
      pre_q <= tick ? '0 : pre_q + 1'b1;
      len_q <= len_nx;
      sat_q <= sat_nx;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      seg_valid_q <= 1'b0;
      seg_level_q <= 1'b1;
      seg_len_q   <= '0;
      seg_sat_q   <= 1'b0;
      sym_valid_q <= 1'b0;
      sym_code_q  <= SYM_ERR;
      idle_q      <= 1'b0;
    end else begin
      // NOTE: strobes default low every cycle; data outputs hold until the next strobe.
      seg_valid_q <= 1'b0;
      sym_valid_q <= 1'b0;
      idle_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (fall) state_q <= ST_MARK;
        end
        ST_MARK: begin
          if (rise) begin
            state_q     <= ST_SPACE;
            seg_valid_q <= 1'b1;
            seg_level_q <= 1'b0;
            seg_len_q   <= len_nx;
            seg_sat_q   <= sat_nx;
            sym_valid_q <= 1'b1;
            sym_code_q  <= classify(1'b0, len_nx, sat_nx);
          end
        end
        ST_SPACE: begin
          // A falling edge takes priority over a timeout landing in the same cycle.
          if (fall) begin
            state_q     <= ST_MARK;
            seg_valid_q <= 1'b1;
            seg_level_q <= 1'b1;
            seg_len_q   <= len_nx;
            seg_sat_q   <= sat_nx;
            sym_valid_q <= 1'b1;
            sym_code_q  <= classify(1'b1, len_nx, sat_nx);
          end else if (len_nx == TIMEOUT_LEN) begin
            state_q     <= ST_IDLE;
            idle_q      <= 1'b1;
            sym_valid_q <= 1'b1;
            sym_code_q  <= SYM_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign seg_valid = seg_valid_q;
  assign seg_level = seg_level_q;
  assign seg_len   = seg_len_q;
  assign seg_sat   = seg_sat_q;
  assign sym_valid = sym_valid_q;
  assign sym_code  = sym_code_q;
  assign idle      = idle_q;

endmodule

// File: tb/tb_ir_pulse_timer.sv
// Scoreboard bench for ir_pulse_timer, scaled to 1 clock per us so full NEC symbol
// timings fit a short run; expected segments are queued as the pin is driven.
module tb_ir_pulse_timer;

  localparam int CLK_PER_US    = 1;
  localparam int FILTER_CYCLES = 3;
  localparam int LEN_W         = 14;
  localparam int TIMEOUT_US    = 5500;
  localparam int LEN_MAX       = (1 << LEN_W) - 1;

  typedef struct {
    bit is_idle;
    bit level;
    int len;
    bit sat;
    int code;
  } exp_t;

  logic             clk, rst_n, rxd;
  logic             seg_valid, seg_level, seg_sat, sym_valid, idle;
  logic [LEN_W-1:0] seg_len;
  logic [2:0]       sym_code;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  ir_pulse_timer #(
    .CLK_PER_US(CLK_PER_US), .FILTER_CYCLES(FILTER_CYCLES),
    .LEN_W(LEN_W), .TIMEOUT_US(TIMEOUT_US)
  ) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .IRDA_RXD(rxd),
    .seg_valid(seg_valid), .seg_level(seg_level), .seg_len(seg_len),
    .seg_sat(seg_sat), .sym_valid(sym_valid), .sym_code(sym_code), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per strobe; idle strobes also check the gap since
  // the previous strobe (the mark that ended the frame).
  initial begin : monitor
    int   cyc;
    int   last_cyc;
    exp_t e;
    cyc      = 0;
    last_cyc = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        cyc++;
        if (seg_valid || sym_valid || idle) begin
          if (exp_q.size() == 0) begin
            check("unexpected_strobe", int'({seg_valid, sym_valid, idle}), 0);
          end else begin
            e = exp_q.pop_front();
            if (e.is_idle) begin
              check("idle_pulse",     int'(idle),      1);
              check("idle_seg_valid", int'(seg_valid), 0);
              check("idle_sym_valid", int'(sym_valid), 1);
              check("idle_code",      int'(sym_code),  7);
              check("idle_gap",       cyc - last_cyc,  TIMEOUT_US * CLK_PER_US);
            end else begin
              check("seg_valid",    int'(seg_valid), 1);
              check("seg_sym_valid", int'(sym_valid), 1);
              check("seg_idle",     int'(idle),      0);
              check("seg_level",    int'(seg_level), int'(e.level));
              check("seg_len",      int'(seg_len),   e.len);
              check("seg_sat",      int'(seg_sat),   int'(e.sat));
              check("sym_code",     int'(sym_code),  e.code);
            end
          end
          last_cyc = cyc;
        end
      end
    end
  end

  task automatic drive(input logic lvl, input int n);
    rxd = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic exp_seg(input bit lvl, input int len, input bit sat, input int code);
    exp_t e;
    e.is_idle = 1'b0; e.level = lvl; e.len = len; e.sat = sat; e.code = code;
    exp_q.push_back(e);
  endtask

  task automatic exp_idle();
    exp_t e;
    e.is_idle = 1'b1; e.level = 1'b1; e.len = 0; e.sat = 1'b0; e.code = 7;
    exp_q.push_back(e);
  endtask

  task automatic mark(input int n, input int code);
    exp_seg(1'b0, n, 1'b0, code);
    drive(1'b0, n);
  endtask

  task automatic space(input int n, input int code);
    exp_seg(1'b1, n, 1'b0, code);
    drive(1'b1, n);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_seg_valid"}, int'(seg_valid), 0);
    check({tag, "_sym_valid"}, int'(sym_valid), 0);
    check({tag, "_idle"},      int'(idle),      0);
    check({tag, "_seg_level"}, int'(seg_level), 1);
    check({tag, "_seg_len"},   int'(seg_len),   0);
    check({tag, "_seg_sat"},   int'(seg_sat),   0);
    check({tag, "_sym_code"},  int'(sym_code),  0);
  endtask

  initial begin : stimulus
    logic [7:0] cmd;
    int sp[6];
    int cd[6];
    sp = '{399, 400, 700, 701, 1900, 1901};
    cd = '{0, 5, 5, 0, 6, 0};
    cmd = 8'h45;

    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;

    // Glitch shorter than the filter is invisible; a 3 us mark gets through.
    drive(1'b1, 20);
    drive(1'b0, FILTER_CYCLES - 1);
    drive(1'b1, 20);
    mark(3, 0);
    space(100, 0);

    // NEC lead plus command byte 0x45 (LSB first), stop mark, then idle.
    mark(9000, 1);
    space(4500, 2);
    for (int i = 0; i < 8; i++) begin
      mark(560, 4);
      if (cmd[i]) space(1690, 6);
      else        space(560, 5);
    end
    mark(560, 4);
    exp_idle();
    drive(1'b1, TIMEOUT_US + 50);

    // Repeat code followed by idle.
    mark(9000, 1);
    space(2250, 3);
    mark(560, 4);
    exp_idle();
    drive(1'b1, TIMEOUT_US + 50);

    // Space window edges.
    mark(560, 4);
    for (int i = 0; i < 6; i++) begin
      space(sp[i], cd[i]);
      mark(560, 4);
    end

    // Space of exactly the timeout: the falling edge wins, no idle pulse.
    space(TIMEOUT_US, 0);

    // Stuck-low line saturates.
    exp_seg(1'b0, LEN_MAX, 1'b1, 0);
    drive(1'b0, LEN_MAX + 120);
    space(100, 0);

    // Reset in the middle of a lead mark discards it.
    drive(1'b0, 2000);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("mid_rst");
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 100);
    mark(560, 4);
    space(560, 5);
    mark(560, 4);
    drive(1'b1, 50);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
